mem_mp_atomic: RTL and testbench

- Parametrised multi-port 64-bit-class scratch memory, next generation of the team's 4-port op-coded memory.
- Adds configurable port count, width and depth, per-port byte enables and an atomic fetch-and-add op.
- Defines deterministic same-cycle multi-port conflict ordering and forwarding across the atomic write-back stage.
- Sits between compute lanes and local storage; one op per port per cycle, no stalls.

---
 rtl/mem_mp_atomic.sv | 126 ++++++++++++
 tb/tb_mem_mp_atomic.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_mp_atomic.sv
// Multi-port scratch memory with per-port byte-enabled writes and atomic fetch-and-add.
// Same-cycle accesses resolve in port order; ADD results sit one cycle in a forwarded write-back stage.
module mem_mp_atomic #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 13,
    parameter int DEPTH     = 8192
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_PORTS*2-1:0]        i_op,
    input  logic [NUM_PORTS*ADDR_W-1:0]   i_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   i_data,
    input  logic [NUM_PORTS*DATA_W/8-1:0] i_be,
    output logic [NUM_PORTS*DATA_W-1:0]   o_data,
    output logic [NUM_PORTS-1:0]          o_valid
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_ADD   = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        op      [NUM_PORTS];
    logic [ADDR_W-1:0] addr    [NUM_PORTS];
    logic [DATA_W-1:0] wdata   [NUM_PORTS];
    logic [BE_W-1:0]   be      [NUM_PORTS];
    logic              in_rng  [NUM_PORTS];
    logic              writer  [NUM_PORTS];
    logic              last    [NUM_PORTS];
    logic              add_any [NUM_PORTS];
    logic [DATA_W-1:0] snap    [NUM_PORTS];
    logic [DATA_W-1:0] cur     [NUM_PORTS];
    logic [DATA_W-1:0] va      [NUM_PORTS];

    logic              wb_valid [NUM_PORTS];
    logic [ADDR_W-1:0] wb_addr  [NUM_PORTS];
    logic [DATA_W-1:0] wb_data  [NUM_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            op[p]     = i_op[2*p +: 2];
            addr[p]   = i_addr[ADDR_W*p +: ADDR_W];
            wdata[p]  = i_data[DATA_W*p +: DATA_W];
            be[p]     = i_be[BE_W*p +: BE_W];
            in_rng[p] = {1'b0, addr[p]} < DEPTH_C;
            writer[p] = in_rng[p] && (op[p] == OP_WRITE || op[p] == OP_ADD);
        end

        // snap: array with last cycle's ADD write-back forwarded; cur: plus lower-port updates
        for (int p = 0; p < NUM_PORTS; p++) begin
            snap[p] = in_rng[p] ? mem[addr[p][IDX_W-1:0]] : '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (in_rng[p] && wb_valid[k] && wb_addr[k] == addr[p])
                    snap[p] = wb_data[k];
            end
            cur[p] = snap[p];
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (q < p && writer[q] && in_rng[p] && addr[q] == addr[p])
                    cur[p] = va[q];
            end
            va[p] = cur[p];
            if (op[p] == OP_ADD) begin
                va[p] = cur[p] + wdata[p];
            end else if (op[p] == OP_WRITE) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[p][b])
                        va[p][8*b +: 8] = wdata[p][8*b +: 8];
                end
            end
        end

        // The last writer of an address carries the final value; it is deferred if any ADD touched it
        for (int p = 0; p < NUM_PORTS; p++) begin
            last[p]    = writer[p];
            add_any[p] = 1'b0;
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (q > p && writer[q] && addr[q] == addr[p])
                    last[p] = 1'b0;
                if (in_rng[q] && op[q] == OP_ADD && addr[q] == addr[p])
                    add_any[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data  <= '0;
            o_valid <= '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                wb_valid[k] <= 1'b0;
                wb_addr[k]  <= '0;
                wb_data[k]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                o_valid[p] <= (op[p] == OP_READ) || (op[p] == OP_ADD);
                case (op[p])
                    OP_READ: o_data[DATA_W*p +: DATA_W] <= snap[p];
                    OP_ADD:  o_data[DATA_W*p +: DATA_W] <= cur[p];
                    default: o_data[DATA_W*p +: DATA_W] <= '0;
                endcase
                wb_valid[p] <= last[p] && add_any[p];
                wb_addr[p]  <= addr[p];
                wb_data[p]  <= va[p];
            end
        end
    end

    // Pending write-back lands first so same-cycle direct writes to that address override it
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (wb_valid[k])
                mem[wb_addr[k][IDX_W-1:0]] <= wb_data[k];
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (last[p] && !add_any[p])
                mem[addr[p][IDX_W-1:0]] <= va[p];
        end
    end
endmodule

// File: tb/tb_mem_mp_atomic.sv
// Bench for mem_mp_atomic: directed scenarios plus randomized traffic against a sequential reference model.
module tb_mem_mp_atomic;
    localparam int NP = 4;
    localparam int DW = 64;
    localparam int AW = 13;
    localparam int DP = 16;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [NP*2-1:0] i_op = '0;
    logic [NP*AW-1:0] i_addr = '0;
    logic [NP*DW-1:0] i_data = '0;
    logic [NP*8-1:0] i_be = '0;
    logic [NP*DW-1:0] o_data;
    logic [NP-1:0]   o_valid;

    mem_mp_atomic #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_op(i_op), .i_addr(i_addr),
        .i_data(i_data), .i_be(i_be), .o_data(o_data), .o_valid(o_valid)
    );

    always #5 i_clk = ~i_clk;

    logic [1:0]    t_op   [NP];
    logic [AW-1:0] t_addr [NP];
    logic [DW-1:0] t_data [NP];
    logic [7:0]    t_be   [NP];
    logic [DW-1:0] lm     [DP];
    logic [DW-1:0] exp_d  [NP];
    logic          exp_v  [NP];
    int checks = 0;
    int errors = 0;

    task automatic set_port(input int p, input logic [1:0] op, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [7:0] be);
        t_op[p] = op; t_addr[p] = a; t_data[p] = d; t_be[p] = be;
    endtask

    // Model: reads see the memory as of the cycle start; WRITE/ADD apply in port order.
    task automatic tick();
        logic [DW-1:0] snapm [DP];
        for (int i = 0; i < DP; i++) snapm[i] = lm[i];
        for (int p = 0; p < NP; p++) begin
            i_op[2*p +: 2]    = t_op[p];
            i_addr[AW*p +: AW] = t_addr[p];
            i_data[DW*p +: DW] = t_data[p];
            i_be[8*p +: 8]     = t_be[p];
            exp_v[p] = (t_op[p] == 2'd1) || (t_op[p] == 2'd3);
            exp_d[p] = '0;
        end
        for (int p = 0; p < NP; p++) begin
            if (t_addr[p] < AW'(DP)) begin
                if (t_op[p] == 2'd1) exp_d[p] = snapm[t_addr[p][3:0]];
                if (t_op[p] == 2'd3) begin
                    exp_d[p] = lm[t_addr[p][3:0]];
                    lm[t_addr[p][3:0]] = lm[t_addr[p][3:0]] + t_data[p];
                end
                if (t_op[p] == 2'd2)
                    for (int b = 0; b < 8; b++)
                        if (t_be[p][b]) lm[t_addr[p][3:0]][8*b +: 8] = t_data[p][8*b +: 8];
            end
        end
        @(posedge i_clk);
        #1;
        for (int p = 0; p < NP; p++) set_port(p, 2'd0, '0, '0, '0);
    endtask

    task automatic init_mem();
        for (int i = 0; i < DP / NP; i++) begin
            for (int p = 0; p < NP; p++) set_port(p, 2'd2, AW'(i*NP + p), '0, 8'hFF);
            tick();
        end
    endtask

    task automatic test_reset();
        for (int p = 0; p < NP; p++) set_port(p, 2'd0, '0, '0, '0);
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", o_valid); end
        checks++;
        if (o_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", o_data); end
        i_rst = 1'b0;
    endtask

    task automatic test_write_read();
        set_port(0, 2'd2, 13'd5, 64'h1122334455667788, 8'hFF);
        tick();
        checks++;
        if (o_valid !== 4'b0000) begin errors++; $display("FAIL wr_valid got %b want 0000", o_valid); end
        set_port(2, 2'd1, 13'd5, '0, '0);
        tick();
        checks++;
        if (o_data[2*DW +: DW] !== 64'h1122334455667788)
            begin errors++; $display("FAIL rd_data got %h want 1122334455667788", o_data[2*DW +: DW]); end
        checks++;
        if (o_valid !== 4'b0100) begin errors++; $display("FAIL rd_valid got %b want 0100", o_valid); end
    endtask

    task automatic test_byte_enable();
        set_port(0, 2'd2, 13'd7, '0, 8'hFF);
        tick();
        set_port(0, 2'd2, 13'd7, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        tick();
        set_port(1, 2'd1, 13'd7, '0, '0);
        tick();
        checks++;
        if (o_data[DW +: DW] !== 64'h00000000FFFFFFFF)
            begin errors++; $display("FAIL be_data got %h want 00000000ffffffff", o_data[DW +: DW]); end
        set_port(0, 2'd2, 13'd7, 64'h0123456789ABCDEF, 8'h00);
        tick();
        set_port(3, 2'd1, 13'd7, '0, '0);
        tick();
        checks++;
        if (o_data[3*DW +: DW] !== 64'h00000000FFFFFFFF)
            begin errors++; $display("FAIL be_zero got %h want 00000000ffffffff", o_data[3*DW +: DW]); end
    endtask

    task automatic test_conflict();
        set_port(0, 2'd2, 13'd9, 64'd10, 8'hFF);
        tick();
        set_port(0, 2'd2, 13'd9, 64'd100, 8'hFF);
        set_port(1, 2'd3, 13'd9, 64'd5, '0);
        set_port(2, 2'd1, 13'd9, '0, '0);
        set_port(3, 2'd3, 13'd9, 64'd1, '0);
        tick();
        checks++;
        if (o_data[DW +: DW] !== 64'd100) begin errors++; $display("FAIL cf_p1 got %0d want 100", o_data[DW +: DW]); end
        checks++;
        if (o_data[2*DW +: DW] !== 64'd10) begin errors++; $display("FAIL cf_p2 got %0d want 10", o_data[2*DW +: DW]); end
        checks++;
        if (o_data[3*DW +: DW] !== 64'd105) begin errors++; $display("FAIL cf_p3 got %0d want 105", o_data[3*DW +: DW]); end
        checks++;
        if (o_valid !== 4'b1110) begin errors++; $display("FAIL cf_valid got %b want 1110", o_valid); end
        set_port(0, 2'd1, 13'd9, '0, '0);
        tick();
        checks++;
        if (o_data[0 +: DW] !== 64'd106) begin errors++; $display("FAIL cf_final got %0d want 106", o_data[0 +: DW]); end
    endtask

    task automatic test_back_to_back();
        set_port(0, 2'd2, 13'd3, '0, 8'hFF);
        tick();
        for (int k = 0; k < 8; k++) begin
            set_port(0, 2'd3, 13'd3, 64'd1, '0);
            set_port(1, 2'd1, 13'd3, '0, '0);
            tick();
            checks++;
            if (o_data[0 +: DW] !== DW'(k))
                begin errors++; $display("FAIL b2b_add k=%0d got %0d want %0d", k, o_data[0 +: DW], k); end
            checks++;
            if (o_data[DW +: DW] !== DW'(k))
                begin errors++; $display("FAIL b2b_read k=%0d got %0d want %0d", k, o_data[DW +: DW], k); end
        end
        set_port(2, 2'd1, 13'd3, '0, '0);
        tick();
        checks++;
        if (o_data[2*DW +: DW] !== 64'd8) begin errors++; $display("FAIL b2b_final got %0d want 8", o_data[2*DW +: DW]); end
    endtask

    task automatic test_reset_mid();
        set_port(0, 2'd2, 13'd4, 64'd50, 8'hFF);
        tick();
        set_port(0, 2'd3, 13'd4, 64'd7, '0);
        tick();
        checks++;
        if (o_data[0 +: DW] !== 64'd50 || o_valid[0] !== 1'b1)
            begin errors++; $display("FAIL rm_add got %0d/%b want 50/1", o_data[0 +: DW], o_valid[0]); end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 4'b0000 || o_data !== '0)
            begin errors++; $display("FAIL rm_clear got valid %b want 0000", o_valid); end
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        lm[4] = 64'd50;
        set_port(1, 2'd1, 13'd4, '0, '0);
        tick();
        checks++;
        if (o_data[DW +: DW] !== 64'd50) begin errors++; $display("FAIL rm_read got %0d want 50", o_data[DW +: DW]); end
    endtask

    task automatic test_out_of_range();
        set_port(0, 2'd2, 13'd20, 64'hAA, 8'hFF);
        tick();
        set_port(0, 2'd1, 13'd20, '0, '0);
        set_port(1, 2'd1, 13'd4, '0, '0);
        set_port(2, 2'd3, 13'd17, 64'd5, '0);
        tick();
        checks++;
        if (o_data[0 +: DW] !== '0 || o_valid[0] !== 1'b1)
            begin errors++; $display("FAIL oor_read got %h/%b want 0/1", o_data[0 +: DW], o_valid[0]); end
        checks++;
        if (o_data[DW +: DW] !== 64'd50) begin errors++; $display("FAIL oor_alias got %0d want 50", o_data[DW +: DW]); end
        checks++;
        if (o_data[2*DW +: DW] !== '0 || o_valid[2] !== 1'b1)
            begin errors++; $display("FAIL oor_add got %h/%b want 0/1", o_data[2*DW +: DW], o_valid[2]); end
        set_port(0, 2'd2, 13'd0, 64'd1, 8'hFF);
        set_port(1, 2'd1, 13'd1, '0, '0);
        tick();
        checks++;
        if (o_data[DW +: DW] !== lm[1]) begin errors++; $display("FAIL oor_addalias got %h want %h", o_data[DW +: DW], lm[1]); end
        set_port(0, 2'd3, 13'd0, 64'hFFFFFFFFFFFFFFFF, '0);
        tick();
        checks++;
        if (o_data[0 +: DW] !== 64'd1) begin errors++; $display("FAIL wrap_old got %0d want 1", o_data[0 +: DW]); end
        set_port(3, 2'd1, 13'd0, '0, '0);
        tick();
        checks++;
        if (o_data[3*DW +: DW] !== 64'd0) begin errors++; $display("FAIL wrap_new got %0d want 0", o_data[3*DW +: DW]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NP; p++) begin
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(16, 40)) : AW'($urandom_range(0, 3));
                d = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 9));
                set_port(p, 2'($urandom_range(0, 3)), a, d, 8'($urandom));
            end
            tick();
            for (int p = 0; p < NP; p++) begin
                checks++;
                if (o_data[p*DW +: DW] !== exp_d[p] || o_valid[p] !== exp_v[p]) begin
                    errors++;
                    $display("FAIL rand n=%0d port %0d got %h/%b want %h/%b",
                             n, p, o_data[p*DW +: DW], o_valid[p], exp_d[p], exp_v[p]);
                end
            end
        end
        for (int i = 0; i < DP; i++) begin
            set_port(i % NP, 2'd1, AW'(i), '0, '0);
            tick();
            checks++;
            if (o_data[(i % NP)*DW +: DW] !== lm[i])
                begin errors++; $display("FAIL rand_final addr %0d got %h want %h", i, o_data[(i % NP)*DW +: DW], lm[i]); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int p = 0; p < NP; p++) set_port(p, 2'd0, '0, '0, '0);
        for (int i = 0; i < DP; i++) lm[i] = '0;
        test_reset();
        init_mem();
        test_write_read();
        test_byte_enable();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
